// File: rtl/fb_dma_sequencer.sv
// Frame-buffer DMA sequencer: programs an Avalon-MM DMA once per vertical blank, then polls for DONE.
// Optional double buffering is built when FB_DOUBLE_BUFFER_EN is defined.
module fb_dma_sequencer #(
  parameter logic [31:0] DMA_CSR_BASE = 32'h0000_0000,
  parameter logic [31:0] FIFO_WR_ADDR = 32'h0000_1000,
  parameter logic [31:0] FRAME_BASE_A = 32'h0000_0000,
  parameter logic [31:0] FRAME_BASE_B = 32'h0020_0000,
  parameter logic [31:0] FRAME_BYTES  = 32'd1228800,
  parameter logic [31:0] CTRL_WORD    = 32'h0000_028C
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        frame_start,
  input  logic        swap_req,
  output logic [31:0] avm_address,
  output logic        avm_write,
  output logic        avm_read,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  input  logic        avm_readdatavalid,
  output logic        busy,
  output logic        frame_done,
  output logic        late_frame,
  output logic [31:0] active_base
);

  localparam logic [31:0] OffStatus = 32'h0000_0000;
  localparam logic [31:0] OffRaddr  = 32'h0000_0004;
  localparam logic [31:0] OffWaddr  = 32'h0000_0008;
  localparam logic [31:0] OffLen    = 32'h0000_000C;
  localparam logic [31:0] OffCtrl   = 32'h0000_0018;

  typedef enum logic [2:0] {
    StIdle,
    StClr,
    StRaddr,
    StWaddr,
    StLen,
    StCtrl,
    StPollRd,
    StPollWt
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] raddr_q, raddr_d;
  logic        write_q, write_d;
  logic        read_q, read_d;
  logic        done_q, done_d;
  logic        late_q, late_d;
  logic [31:0] base_q;
  logic        accepted;

  assign accepted = (write_q | read_q) & ~avm_waitrequest;

  // Command registers are loaded with the next state's command, so outputs stay registered.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    raddr_d = raddr_q;
    write_d = write_q;
    read_d  = read_q;
    done_d  = 1'b0;
    late_d  = late_q | (frame_start & (state_q != StIdle));
    unique case (state_q)
      StIdle: begin
        if (frame_start && enable) begin
          state_d = StClr;
          write_d = 1'b1;
          addr_d  = DMA_CSR_BASE + OffStatus;
          wdata_d = 32'h0;
          raddr_d = base_q;
        end
      end
      StClr: begin
        if (accepted) begin
          state_d = StRaddr;
          addr_d  = DMA_CSR_BASE + OffRaddr;
          wdata_d = raddr_q;
        end
      end
      StRaddr: begin
        if (accepted) begin
          state_d = StWaddr;
          addr_d  = DMA_CSR_BASE + OffWaddr;
          wdata_d = FIFO_WR_ADDR;
        end
      end
      StWaddr: begin
        if (accepted) begin
          state_d = StLen;
          addr_d  = DMA_CSR_BASE + OffLen;
          wdata_d = FRAME_BYTES;
        end
      end
      StLen: begin
        if (accepted) begin
          state_d = StCtrl;
          addr_d  = DMA_CSR_BASE + OffCtrl;
          wdata_d = CTRL_WORD;
        end
      end
      StCtrl: begin
        if (accepted) begin
          state_d = StPollRd;
          write_d = 1'b0;
          read_d  = 1'b1;
          addr_d  = DMA_CSR_BASE + OffStatus;
          wdata_d = 32'h0;
        end
      end
      StPollRd: begin
        if (accepted) begin
          state_d = StPollWt;
          read_d  = 1'b0;
        end
      end
      StPollWt: begin
        if (avm_readdatavalid) begin
          if (avm_readdata[0]) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            state_d = StPollRd;
            read_d  = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      raddr_q <= 32'h0;
      write_q <= 1'b0;
      read_q  <= 1'b0;
      done_q  <= 1'b0;
      late_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      raddr_q <= raddr_d;
      write_q <= write_d;
      read_q  <= read_d;
      done_q  <= done_d;
      late_q  <= late_d;
    end
  end

`ifdef FB_DOUBLE_BUFFER_EN
  logic sel_q, sel_d;
  logic pend_q, pend_d;
  logic pend_eff;

  // A request arriving in the frame_done cycle still swaps that frame.
  always_comb begin
    pend_eff = pend_q | swap_req;
    pend_d   = pend_eff;
    sel_d    = sel_q;
    if (done_q && pend_eff) begin
      sel_d  = ~sel_q;
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sel_q  <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      sel_q  <= sel_d;
      pend_q <= pend_d;
    end
  end

  assign base_q = sel_q ? FRAME_BASE_B : FRAME_BASE_A;
`else
  logic unused_cfg;
  assign unused_cfg = swap_req ^ (^FRAME_BASE_B);
  assign base_q     = FRAME_BASE_A;
`endif

  logic unused_rdata;
  assign unused_rdata = ^avm_readdata[31:1];

  assign avm_address   = addr_q;
  assign avm_writedata = wdata_q;
  assign avm_write     = write_q;
  assign avm_read      = read_q;
  assign busy          = (state_q != StIdle);
  assign frame_done    = done_q;
  assign late_frame    = late_q;
  assign active_base   = base_q;

endmodule

// File: tb/tb_fb_dma_sequencer.sv
// Self-checking bench for fb_dma_sequencer: scoreboarded CSR writes, polled status reads,
// stalls, late frames, enable drop, buffer swap and mid-transaction reset.
module tb_fb_dma_sequencer;

  localparam logic [31:0] CsrBase    = 32'h0000_0000;
  localparam logic [31:0] FifoAddr   = 32'h0000_1000;
  localparam logic [31:0] BaseA      = 32'h0000_0000;
  localparam logic [31:0] BaseB      = 32'h0020_0000;
  localparam logic [31:0] FrameBytes = 32'd1228800;
  localparam logic [31:0] CtrlWord   = 32'h0000_028C;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        frame_start = 1'b0;
  logic        swap_req = 1'b0;
  logic [31:0] avm_address;
  logic        avm_write;
  logic        avm_read;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata = 32'h0;
  logic        avm_waitrequest = 1'b0;
  logic        avm_readdatavalid = 1'b0;
  logic        busy;
  logic        frame_done;
  logic        late_frame;
  logic [31:0] active_base;

  fb_dma_sequencer dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .enable            (enable),
    .frame_start       (frame_start),
    .swap_req          (swap_req),
    .avm_address       (avm_address),
    .avm_write         (avm_write),
    .avm_read          (avm_read),
    .avm_writedata     (avm_writedata),
    .avm_readdata      (avm_readdata),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdatavalid (avm_readdatavalid),
    .busy              (busy),
    .frame_done        (frame_done),
    .late_frame        (late_frame),
    .active_base       (active_base)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  int          n_checks = 0;
  int          n_pass = 0;
  wr_t         wr_q[$];
  logic [31:0] stat_q[$];
  int          wr_cyc_q[$];
  int          cyc = 0;
  int          rd_count = 0;
  int          fd_count = 0;
  int          len_cycles = 0;
  bit          len_data_bad = 1'b0;
  bit          rw_overlap = 1'b0;
  logic [31:0] stall_addr = 32'hFFFF_FFFF;
  int          stall_left = 0;
  logic [31:0] exp_base = BaseA;
  bit          exp_pend = 1'b0;
  wr_t         mon_exp;
  bit          rd_acc;

  always @(posedge clock) cyc++;

  // Write scoreboard and bus monitor, sampled mid-cycle.
  always @(negedge clock) begin
    if (avm_read && avm_write) rw_overlap = 1'b1;
    if (frame_done) fd_count++;
    if (avm_write && avm_address == CsrBase + 32'h0C) begin
      len_cycles++;
      if (avm_writedata !== FrameBytes) len_data_bad = 1'b1;
    end
    if (avm_write && !avm_waitrequest) begin
      n_checks++;
      wr_cyc_q.push_back(cyc);
      if (wr_q.size() == 0) begin
        $display("FAIL wr_unexpected: got addr %h data %h, expected no write",
                 avm_address, avm_writedata);
      end else begin
        mon_exp = wr_q.pop_front();
        if ({avm_address, avm_writedata} !== {mon_exp.addr, mon_exp.data})
          $display("FAIL wr_scoreboard: got addr %h data %h, expected addr %h data %h",
                   avm_address, avm_writedata, mon_exp.addr, mon_exp.data);
        else n_pass++;
      end
    end
  end

  // Slave: one-cycle read latency, optional stall on a chosen write address.
  always begin
    @(posedge clock);
    rd_acc = reset_n && avm_read && !avm_waitrequest;
    #1;
    avm_readdatavalid = 1'b0;
    if (rd_acc) begin
      rd_count++;
      avm_readdatavalid = 1'b1;
      if (stat_q.size() > 0) avm_readdata = stat_q.pop_front();
      else avm_readdata = 32'h1;
    end
    if (stall_left > 0 && avm_write && avm_address == stall_addr) begin
      avm_waitrequest = 1'b1;
      stall_left--;
    end else begin
      avm_waitrequest = 1'b0;
    end
  end

  task automatic push_frame(input int n_busy);
    wr_q.push_back('{CsrBase + 32'h00, 32'h0});
    wr_q.push_back('{CsrBase + 32'h04, exp_base});
    wr_q.push_back('{CsrBase + 32'h08, FifoAddr});
    wr_q.push_back('{CsrBase + 32'h0C, FrameBytes});
    wr_q.push_back('{CsrBase + 32'h18, CtrlWord});
    for (int i = 0; i < n_busy; i++) stat_q.push_back(32'h2);
    stat_q.push_back(32'h1);
  endtask

  task automatic run_frame(input int n_busy, input bit late_pulse, input bit drop_en,
                           input bit swap_at_done, input string tag);
    bit done_seen = 1'b0;
    bit late_sent = 1'b0;
    push_frame(n_busy);
    rd_count = 0;
    fd_count = 0;
    @(posedge clock); #1;
    enable = 1'b1;
    frame_start = 1'b1;
    @(posedge clock); #1;
    frame_start = 1'b0;
    n_checks++;
    if (avm_write !== 1'b1 || avm_address !== CsrBase)
      $display("FAIL %s_first_write: got write %b addr %h, expected write 1 addr %h",
               tag, avm_write, avm_address, CsrBase);
    else n_pass++;
    if (drop_en) enable = 1'b0;
    for (int i = 0; i < 400 && !done_seen; i++) begin
      @(posedge clock); #1;
      frame_start = 1'b0;
      if (late_pulse && !late_sent && avm_read) begin
        frame_start = 1'b1;
        late_sent = 1'b1;
      end
      if (frame_done) begin
        done_seen = 1'b1;
        if (swap_at_done) swap_req = 1'b1;
      end
    end
    n_checks++;
    if (!done_seen) $display("FAIL %s_done_timeout: got no frame_done, expected one", tag);
    else n_pass++;
`ifdef FB_DOUBLE_BUFFER_EN
    if (done_seen && (exp_pend || swap_at_done)) begin
      exp_base = (exp_base == BaseA) ? BaseB : BaseA;
      exp_pend = 1'b0;
    end
`endif
    @(posedge clock); #1;
    frame_start = 1'b0;
    swap_req = 1'b0;
    @(posedge clock); #1;
    n_checks++;
    if (rd_count !== n_busy + 1 || fd_count !== 1 || busy !== 1'b0 || wr_q.size() != 0)
      $display("FAIL %s_end: got reads %0d done_cycles %0d busy %b left %0d, expected %0d 1 0 0",
               tag, rd_count, fd_count, busy, wr_q.size(), n_busy + 1);
    else n_pass++;
    n_checks++;
    if (active_base !== exp_base)
      $display("FAIL %s_active_base: got %h, expected %h", tag, active_base, exp_base);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #12;
    n_checks++;
    if ({avm_write, avm_read, avm_address, avm_writedata} !== {2'b00, 64'h0})
      $display("FAIL reset_bus: got w %b r %b addr %h data %h, expected all zero",
               avm_write, avm_read, avm_address, avm_writedata);
    else n_pass++;
    n_checks++;
    if ({busy, frame_done, late_frame, active_base} !== {3'b000, BaseA})
      $display("FAIL reset_status: got busy %b done %b late %b base %h, expected 0 0 0 %h",
               busy, frame_done, late_frame, active_base, BaseA);
    else n_pass++;
    @(posedge clock); #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    n_checks++;
    if (busy !== 1'b0 || avm_write !== 1'b0)
      $display("FAIL reset_idle_hold: got busy %b write %b, expected 0 0", busy, avm_write);
    else n_pass++;
  endtask

  task automatic test_basic();
    wr_cyc_q.delete();
    run_frame(0, 1'b0, 1'b0, 1'b0, "basic");
    n_checks++;
    if (wr_cyc_q.size() != 5 || wr_cyc_q[4] - wr_cyc_q[0] != 4)
      $display("FAIL basic_one_per_cycle: got %0d writes spanning %0d cycles, expected 5 over 4",
               wr_cyc_q.size(), (wr_cyc_q.size() == 5) ? wr_cyc_q[4] - wr_cyc_q[0] : -1);
    else n_pass++;
  endtask

  task automatic test_poll();
    run_frame(2, 1'b0, 1'b0, 1'b0, "poll");
  endtask

  task automatic test_stall();
    len_cycles = 0;
    len_data_bad = 1'b0;
    stall_addr = CsrBase + 32'h0C;
    stall_left = 3;
    run_frame(0, 1'b0, 1'b0, 1'b0, "stall");
    n_checks++;
    if (len_cycles != 4 || len_data_bad)
      $display("FAIL stall_len_hold: got %0d cycles data_bad %b, expected 4 cycles stable",
               len_cycles, len_data_bad);
    else n_pass++;
  endtask

  task automatic test_late();
    run_frame(1, 1'b1, 1'b0, 1'b0, "late");
    repeat (5) @(posedge clock);
    #1;
    n_checks++;
    if (late_frame !== 1'b1 || busy !== 1'b0)
      $display("FAIL late_sticky: got late %b busy %b, expected 1 0", late_frame, busy);
    else n_pass++;
  endtask

  task automatic test_enable_drop();
    run_frame(1, 1'b0, 1'b1, 1'b0, "endrop");
    @(posedge clock); #1;
    frame_start = 1'b1;
    @(posedge clock); #1;
    frame_start = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    n_checks++;
    if (busy !== 1'b0 || avm_write !== 1'b0)
      $display("FAIL endrop_hold_idle: got busy %b write %b, expected 0 0", busy, avm_write);
    else n_pass++;
    enable = 1'b1;
  endtask

  task automatic test_swap();
    @(posedge clock); #1;
    swap_req = 1'b1;
`ifdef FB_DOUBLE_BUFFER_EN
    exp_pend = 1'b1;
`endif
    @(posedge clock); #1;
    swap_req = 1'b0;
    n_checks++;
    if (active_base !== BaseA)
      $display("FAIL swap_not_early: got %h, expected %h", active_base, BaseA);
    else n_pass++;
    run_frame(0, 1'b0, 1'b0, 1'b0, "swap1");
    run_frame(1, 1'b0, 1'b0, 1'b1, "swap2");
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    push_frame(0);
    stall_addr = CsrBase + 32'h18;
    stall_left = 1000;
    @(posedge clock); #1;
    frame_start = 1'b1;
    @(posedge clock); #1;
    frame_start = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(posedge clock); #1;
      if (avm_write && avm_address == CsrBase + 32'h18) seen = 1'b1;
    end
    @(posedge clock); #2;
    n_checks++;
    if (!seen || avm_waitrequest !== 1'b1)
      $display("FAIL rstmid_ctrl_stall: got seen %b wait %b, expected 1 1", seen, avm_waitrequest);
    else n_pass++;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({avm_write, avm_read, avm_address, avm_writedata} !== {2'b00, 64'h0})
      $display("FAIL rstmid_bus: got w %b r %b addr %h data %h, expected all zero",
               avm_write, avm_read, avm_address, avm_writedata);
    else n_pass++;
    n_checks++;
    if ({busy, frame_done, late_frame, active_base} !== {3'b000, BaseA})
      $display("FAIL rstmid_status: got busy %b done %b late %b base %h, expected 0 0 0 %h",
               busy, frame_done, late_frame, active_base, BaseA);
    else n_pass++;
    wr_q.delete();
    stat_q.delete();
    stall_left = 0;
    exp_base = BaseA;
    exp_pend = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    run_frame(0, 1'b0, 1'b0, 1'b0, "recover");
  endtask

  task automatic test_protocol();
    n_checks++;
    if (rw_overlap !== 1'b0)
      $display("FAIL rw_exclusive: got read/write overlap %b, expected 0", rw_overlap);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_poll();
    test_stall();
    test_late();
    test_enable_drop();
    test_swap();
    test_reset_mid();
    test_protocol();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fb_dma_sequencer.md
FB_DMA_SEQUENCER -- requirements
Module: fb_dma_sequencer

Interface
REQ-001 SHALL have parameter DMA_CSR_BASE, default 32'h0000_0000, Avalon byte address of the DMA register file.
REQ-002 SHALL have parameter FIFO_WR_ADDR, default 32'h0000_1000, FIFO write-port address used as the DMA destination.
REQ-003 SHALL have parameter FRAME_BASE_A, default 32'h0000_0000, SDRAM byte address of frame A.
REQ-004 SHALL have parameter FRAME_BASE_B, default 32'h0020_0000, SDRAM byte address of frame B.
REQ-005 SHALL have parameter FRAME_BYTES, default 32'd1228800, transfer length per frame (640x480x4).
REQ-006 SHALL have parameter CTRL_WORD, default 32'h0000_028C, DMA control value (WORD|GO|LEEN|WCON).
REQ-007 clock  in  1  single clock for all logic.
REQ-008 reset_n  in  1  asynchronous, active-low reset.
REQ-009 enable  in  1  level; permits starting new frame transfers.
REQ-010 frame_start  in  1  one-cycle pulse at start of vertical blanking.
REQ-011 swap_req  in  1  one-cycle pulse requesting a frame-buffer swap.
REQ-012 avm_address  out  32  Avalon-MM master byte address.
REQ-013 avm_write / avm_read  out  1 each  Avalon command strobes.
REQ-014 avm_writedata  out  32  write data.
REQ-015 avm_readdata  in  32  read data.
REQ-016 avm_waitrequest  in  1  slave stall.
REQ-017 avm_readdatavalid  in  1  read data qualifier.
REQ-018 busy  out  1  high in any state other than IDLE.
REQ-019 frame_done  out  1  one-cycle pulse when DMA reports DONE.
REQ-020 late_frame  out  1  sticky; frame_start seen while not IDLE.
REQ-021 active_base  out  32  SDRAM base of the frame currently scanned out.

Function
REQ-022 SHALL implement states IDLE, CLR, RADDR, WADDR, LEN, CTRL, POLL_RD, POLL_WT.
REQ-023 IDLE -> CLR when frame_start & enable in same cycle; otherwise remain.
REQ-024 CLR writes 0 to offset 0x00; RADDR writes active_base to 0x04; WADDR writes FIFO_WR_ADDR to 0x08; LEN writes FRAME_BYTES to 0x0C; CTRL writes CTRL_WORD to 0x18; addresses are DMA_CSR_BASE + offset.
REQ-025 Each command SHALL hold address, data and strobe stable while avm_waitrequest=1 and advance state on the first cycle with strobe=1 and waitrequest=0.
REQ-026 avm_read and avm_write SHALL never be asserted together; at most one read outstanding.
REQ-027 POLL_RD issues read of offset 0x00, then POLL_WT waits for avm_readdatavalid.
REQ-028 POLL_WT: readdata[0]=1 -> IDLE with frame_done=1 that cycle's successor (registered, one cycle wide); readdata[0]=0 -> POLL_RD.
REQ-029 frame_start when state!=IDLE SHALL set late_frame and be otherwise ignored (no queuing).
REQ-030 Deasserting enable mid-sequence SHALL NOT abort; sequence completes, then IDLE holds.
REQ-031 active_base SHALL be sampled into RADDR data at CLR entry; changes after that apply next frame.
REQ-032 Minimum latency frame_start to first avm_write: 1 cycle (registered outputs).

Reset
REQ-033 On reset_n=0, asynchronously: state=IDLE, avm_read=avm_write=0, avm_address=0, avm_writedata=0, frame_done=0, late_frame=0, busy=0, active_base=FRAME_BASE_A, swap pending=0.
REQ-034 Reset mid-transaction SHALL drop strobes immediately; no completion of the pending command.

Configuration
REQ-035 FB_DOUBLE_BUFFER_EN defined: swap_req sets a pending flag; on the frame_done cycle with flag set, active_base toggles A<->B and flag clears; swap_req and frame_done coincident SHALL swap that frame.
REQ-036 FB_DOUBLE_BUFFER_EN undefined: swap_req ignored, no pending flag, active_base fixed at FRAME_BASE_A.

Verification
REQ-037 Reset, enable=1, frame_start pulse, waitrequest=0 -> writes 0@0x00, 0x0@0x04, 0x1000@0x08, 1228800@0x0C, 0x28C@0x18 in order, one per cycle.
REQ-038 waitrequest held 3 cycles on LEN write -> address 0x0C and data 1228800 stable 4 cycles, single acceptance.
REQ-039 status reads return 0x2, 0x2, 0x1 -> three reads, frame_done single pulse, busy falls, state IDLE.
REQ-040 frame_start pulsed during POLL -> late_frame=1 and stays 1 until reset; no extra CSR writes.
REQ-041 With FB_DOUBLE_BUFFER_EN: swap_req, complete frame -> active_base=0x0020_0000; next frame RADDR data 0x0020_0000; without macro -> remains 0x0.
REQ-042 reset_n low during CTRL write with waitrequest=1 -> avm_write=0 same cycle, outputs at REQ-033 values.
